// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bus of the dual-clock FIFO write controller.
// FIFO_WR_CTRL_OVF_CNT_EN adds the dropped-write counter ovf_cnt_o.
interface fifo_wr_ctrl_if #(
   parameter int ADDR_WIDTH = 3
);
   logic                  wr_en_i;
   logic [ADDR_WIDTH:0]   rd_ptr_gray_i;
   logic                  clr_ovf_i;
   logic [ADDR_WIDTH-1:0] wr_ptr_o;
   logic [ADDR_WIDTH:0]   wr_ptr_gray_o;
   logic                  wr_valid_o;
   logic                  full_o;
   logic                  almost_full_o;
   logic [ADDR_WIDTH:0]   wr_cnt_o;
   logic                  overflow_o;
`ifdef FIFO_WR_CTRL_OVF_CNT_EN
   logic [7:0]            ovf_cnt_o;
`endif

`ifdef FIFO_WR_CTRL_OVF_CNT_EN
   modport master (
      output wr_en_i, rd_ptr_gray_i, clr_ovf_i,
      input  wr_ptr_o, wr_ptr_gray_o, wr_valid_o, full_o, almost_full_o,
             wr_cnt_o, overflow_o, ovf_cnt_o
   );
   modport slave (
      input  wr_en_i, rd_ptr_gray_i, clr_ovf_i,
      output wr_ptr_o, wr_ptr_gray_o, wr_valid_o, full_o, almost_full_o,
             wr_cnt_o, overflow_o, ovf_cnt_o
   );
`else
   modport master (
      output wr_en_i, rd_ptr_gray_i, clr_ovf_i,
      input  wr_ptr_o, wr_ptr_gray_o, wr_valid_o, full_o, almost_full_o,
             wr_cnt_o, overflow_o
   );
   modport slave (
      input  wr_en_i, rd_ptr_gray_i, clr_ovf_i,
      output wr_ptr_o, wr_ptr_gray_o, wr_valid_o, full_o, almost_full_o,
             wr_cnt_o, overflow_o
   );
`endif
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-clock-domain controller of the dual-clock FIFO: pointers, full/almost-full, fill level, overflow.
// Optional macro FIFO_WR_CTRL_OVF_CNT_EN adds a saturating dropped-write counter.
module fifo_wr_ctrl #(
   parameter int DLY          = 1,
   parameter int ADDR_WIDTH   = 3,
   parameter int AFULL_THRESH = 6
) (
   input logic           wr_clk_i,
   input logic           rst_n_i,
   fifo_wr_ctrl_if.slave bus
);
   localparam int AW = ADDR_WIDTH;
   localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_THRESH);

   if ((ADDR_WIDTH < 2) || (AFULL_THRESH < 1) || (AFULL_THRESH > 2**ADDR_WIDTH) || (DLY < 0)) begin : g_bad_cfg
      $error("fifo_wr_ctrl: illegal parameter set");
   end

   function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
      return (b >> 1) ^ b;
   endfunction

   function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
      logic [AW:0] b;
      b[AW] = g[AW];
      for (int i = AW - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [AW:0] wbin_r;
   logic [AW:0] gray_r;
   logic        full_r;
   logic        afull_r;
   logic [AW:0] cnt_r;
   logic        ovf_r;

   logic        accept_s;
   logic        drop_s;
   logic [AW:0] wbin_next_s;
   logic [AW:0] rbin_s;
   logic [AW:0] fill_s;
   logic [AW:0] gray_next_s;
   logic [AW:0] full_ref_s;
   logic        full_next_s;

   // next-state pointer arithmetic; no RAM strobe while reset is held
   always_comb begin
      accept_s    = bus.wr_en_i & ~full_r & rst_n_i;
      drop_s      = bus.wr_en_i & full_r;
      wbin_next_s = wbin_r + {{AW{1'b0}}, accept_s};
      rbin_s      = gray2bin(bus.rd_ptr_gray_i);
      fill_s      = wbin_next_s - rbin_s;
      gray_next_s = bin2gray(wbin_next_s);
      full_ref_s  = {~bus.rd_ptr_gray_i[AW:AW-1], bus.rd_ptr_gray_i[AW-2:0]};
      full_next_s = (gray_next_s == full_ref_s);
   end

   // pointer, status and sticky overflow registers
   always_ff @(posedge wr_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wbin_r  <= '0;
         gray_r  <= '0;
         full_r  <= 1'b0;
         afull_r <= 1'b0;
         cnt_r   <= '0;
         ovf_r   <= 1'b0;
      end else begin
         wbin_r  <= wbin_next_s;
         gray_r  <= gray_next_s;
         full_r  <= full_next_s;
         afull_r <= (fill_s >= AFULL_C);
         cnt_r   <= fill_s;
         // a new drop outranks a same-cycle clear
         ovf_r   <= drop_s | (ovf_r & ~bus.clr_ovf_i);
      end
   end

`ifdef FIFO_WR_CTRL_OVF_CNT_EN
   logic [7:0] ovf_cnt_r;

   // saturating count of dropped writes; a drop in the clearing cycle counts as the first
   always_ff @(posedge wr_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ovf_cnt_r <= 8'd0;
      end else if (drop_s && bus.clr_ovf_i) begin
         ovf_cnt_r <= 8'd1;
      end else if (bus.clr_ovf_i) begin
         ovf_cnt_r <= 8'd0;
      end else if (drop_s && (ovf_cnt_r != 8'd255)) begin
         ovf_cnt_r <= ovf_cnt_r + 8'd1;
      end else begin
         ovf_cnt_r <= ovf_cnt_r;
      end
   end

   assign bus.ovf_cnt_o = ovf_cnt_r;
`endif

   assign bus.wr_ptr_o      = wbin_r[AW-1:0];
   assign bus.wr_ptr_gray_o = gray_r;
   assign bus.wr_valid_o    = accept_s;
   assign bus.full_o        = full_r;
   assign bus.almost_full_o = afull_r;
   assign bus.wr_cnt_o      = cnt_r;
   assign bus.overflow_o    = ovf_r;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: integer write/read counts model the FIFO occupancy.
module tb_fifo_wr_ctrl;
   localparam int AW = 3;
   localparam int D  = 8;
   localparam int TH = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   fifo_wr_ctrl #(.DLY(1), .ADDR_WIDTH(AW), .AFULL_THRESH(TH)) dut (
      .wr_clk_i(clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   typedef struct { int valid; int ptr; } comb_t;
   typedef struct { int gray; int cnt; int full; int afull; int ovf; int ocnt; } reg_t;

   comb_t comb_q[$];
   reg_t  reg_q[$];
   int checks   = 0;
   int failures = 0;

   // reference state: total writes accepted, total reads seen, registered flags
   int m_w, m_r, m_full, m_ovf, m_ocnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [AW:0] gray(input int v);
      logic [AW:0] b;
      b = (AW+1)'(v % (2*D));
      return b ^ (b >> 1);
   endfunction

   task automatic model_reset();
      m_w = 0; m_r = 0; m_full = 0; m_ovf = 0; m_ocnt = 0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_wr_valid"}, bus.wr_valid_o, 0);
      chk({tag, "_wr_ptr"}, bus.wr_ptr_o, 0);
      chk({tag, "_gray"}, bus.wr_ptr_gray_o, 0);
      chk({tag, "_full"}, bus.full_o, 0);
      chk({tag, "_afull"}, bus.almost_full_o, 0);
      chk({tag, "_cnt"}, bus.wr_cnt_o, 0);
      chk({tag, "_ovf"}, bus.overflow_o, 0);
`ifdef FIFO_WR_CTRL_OVF_CNT_EN
      chk({tag, "_ovf_cnt"}, bus.ovf_cnt_o, 0);
`endif
   endtask

   // drive one cycle of stimulus and predict the DUT response to it
   task automatic step(input bit en, input bit clr, input int r_new);
      comb_t c;
      reg_t  e;
      int    acc, drop, fill;
      @(negedge clk);
      bus.wr_en_i       = en;
      bus.clr_ovf_i     = clr;
      bus.rd_ptr_gray_i = gray(r_new);
      acc  = (en && !m_full) ? 1 : 0;
      drop = (en && m_full) ? 1 : 0;
      c.valid = acc;
      c.ptr   = m_w % D;
      comb_q.push_back(c);
      m_w  = m_w + acc;
      m_r  = r_new;
      fill = m_w - m_r;
      if (drop != 0)  m_ovf = 1;
      else if (clr)   m_ovf = 0;
      if (drop != 0 && clr)  m_ocnt = 1;
      else if (clr)          m_ocnt = 0;
      else if (drop != 0)    m_ocnt = (m_ocnt < 255) ? m_ocnt + 1 : 255;
      m_full  = (fill == D) ? 1 : 0;
      e.gray  = int'(gray(m_w));
      e.cnt   = fill;
      e.full  = m_full;
      e.afull = (fill >= TH) ? 1 : 0;
      e.ovf   = m_ovf;
      e.ocnt  = m_ocnt;
      reg_q.push_back(e);
   endtask

   // combinational monitor: strobe and address ahead of the edge
   initial begin : mon_comb
      comb_t c;
      forever begin
         @(negedge clk);
         #2;
         if (comb_q.size() > 0) begin
            c = comb_q.pop_front();
            chk("wr_valid", bus.wr_valid_o, c.valid);
            chk("wr_ptr", bus.wr_ptr_o, c.ptr);
         end
      end
   end

   // registered monitor: state after the edge
   initial begin : mon_reg
      reg_t e;
      forever begin
         @(posedge clk);
         #1;
         if (reg_q.size() > 0) begin
            e = reg_q.pop_front();
            chk("wr_ptr_gray", bus.wr_ptr_gray_o, e.gray);
            chk("wr_cnt", bus.wr_cnt_o, e.cnt);
            chk("full", bus.full_o, e.full);
            chk("almost_full", bus.almost_full_o, e.afull);
            chk("overflow", bus.overflow_o, e.ovf);
`ifdef FIFO_WR_CTRL_OVF_CNT_EN
            chk("ovf_cnt", bus.ovf_cnt_o, e.ocnt);
`endif
         end
      end
   end

   initial begin : main
      int rn;
      bus.wr_en_i       = 1'b0;
      bus.clr_ovf_i     = 1'b0;
      bus.rd_ptr_gray_i = '0;
      model_reset();

      // reset held while wr_en toggles
      repeat (4) begin
         @(negedge clk);
         bus.wr_en_i = ~bus.wr_en_i;
         #2;
         check_all_zero("rst_hold");
      end
      @(negedge clk);
      bus.wr_en_i = 1'b0;
      rst_n = 1'b1;

      // fill to full, overflow, clear, partial drain
      step(1'b1, 1'b0, 0);
      repeat (7) step(1'b1, 1'b0, 0);
      repeat (3) step(1'b1, 1'b0, 0);
      step(1'b0, 1'b1, 0);
      step(1'b0, 1'b0, 3);

      // sustained write plus read with pointer wrap
      for (int i = 0; i < 40; i++) step(1'b1, 1'b0, m_r + 1);

      // randomized traffic, reads never overtake writes
      for (int i = 0; i < 400; i++) begin
         rn = m_r;
         if ($urandom_range(0, 2) == 0) rn = m_r + $urandom_range(0, m_w - m_r);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rn);
      end

      // asynchronous reset between edges
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(negedge clk);
      bus.wr_en_i = 1'b0;
      model_reset();
      rst_n = 1'b1;

      // five writes then reset mid-cycle
      repeat (5) step(1'b1, 1'b0, 0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_fill_rst");
      @(negedge clk);
      bus.wr_en_i = 1'b0;
      model_reset();
      rst_n = 1'b1;

      step(1'b1, 1'b0, 0);
      step(1'b0, 1'b0, 0);
      @(posedge clk);
      #3;
      chk("queues_drained", comb_q.size() + reg_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
